// File: rtl/q_rail_receiver.sv
// Clocked consumer of the Q-flop dual-rail resolver: synchronises the active-low
// rail pair, enforces return-to-spacer, and hands the resolved bit out via valid/ready.
module q_rail_receiver #(
  parameter int unsigned TIMEOUT = 8,
  parameter int unsigned SETTLE  = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rh_l,
  input  logic       rl_l,
  input  logic       arm,
  output logic       armed,
  output logic       out_valid,
  output logic       out_data,
  input  logic       out_ready,
  output logic       timeout,
  output logic       conflict,
  output logic [7:0] err_count
);

  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  localparam int unsigned SW = $clog2(SETTLE + 1);
  localparam logic [TW-1:0] TIMER_LAST  = TW'(TIMEOUT - 1);
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_SPACER,
    S_WAIT_RAIL,
    S_HOLD,
    S_ERR
  } state_t;

  state_t        r_state;
  logic          r_rh_s1, r_rh_s2;
  logic          r_rl_s1, r_rl_s2;
  logic [TW-1:0] r_timer;
  logic [SW-1:0] r_settle;
  logic          r_data;
  logic          r_timeout;
  logic          r_conflict;
  logic [7:0]    r_err_count;

  state_t        w_state_nxt;
  logic [TW-1:0] w_timer_nxt;
  logic [SW-1:0] w_settle_nxt;
  logic          w_data_nxt;
  logic          w_timeout_nxt;
  logic          w_conflict_nxt;
  logic [7:0]    w_err_nxt;
  logic          w_rh_fired;
  logic          w_rl_fired;

  assign w_rh_fired = ~r_rh_s2;
  assign w_rl_fired = ~r_rl_s2;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_rh_s1     <= 1'b1;
      r_rh_s2     <= 1'b1;
      r_rl_s1     <= 1'b1;
      r_rl_s2     <= 1'b1;
      r_timer     <= '0;
      r_settle    <= '0;
      r_data      <= 1'b0;
      r_timeout   <= 1'b0;
      r_conflict  <= 1'b0;
      r_err_count <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_rh_s1     <= rh_l;
      r_rh_s2     <= r_rh_s1;
      r_rl_s1     <= rl_l;
      r_rl_s2     <= r_rl_s1;
      r_timer     <= w_timer_nxt;
      r_settle    <= w_settle_nxt;
      r_data      <= w_data_nxt;
      r_timeout   <= w_timeout_nxt;
      r_conflict  <= w_conflict_nxt;
      r_err_count <= w_err_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_timer_nxt    = r_timer;
    w_settle_nxt   = r_settle;
    w_data_nxt     = r_data;
    w_timeout_nxt  = r_timeout;
    w_conflict_nxt = r_conflict;
    w_err_nxt      = r_err_count;

    unique case (r_state)
      S_IDLE: begin
        if (arm) w_state_nxt = S_WAIT_SPACER;
      end
      S_WAIT_SPACER: begin
        if (!w_rh_fired && !w_rl_fired) begin
          if (r_settle == SETTLE_LAST) w_state_nxt = S_WAIT_RAIL;
          else                         w_settle_nxt = r_settle + 1'b1;
        end else begin
          w_settle_nxt = '0;
        end
      end
      S_WAIT_RAIL: begin
        // A rail seen on the last timer cycle takes precedence over timeout.
        if (w_rh_fired && w_rl_fired) begin
          w_state_nxt    = S_ERR;
          w_conflict_nxt = 1'b1;
        end else if (w_rh_fired || w_rl_fired) begin
          w_state_nxt = S_HOLD;
          w_data_nxt  = w_rh_fired;
        end else if (r_timer == TIMER_LAST) begin
          w_state_nxt   = S_ERR;
          w_timeout_nxt = 1'b1;
        end else begin
          w_timer_nxt = r_timer + 1'b1;
        end
      end
      S_HOLD: begin
        if (out_ready) w_state_nxt = arm ? S_WAIT_SPACER : S_IDLE;
      end
      S_ERR: begin
        if (arm) begin
          w_state_nxt    = S_WAIT_SPACER;
          w_timeout_nxt  = 1'b0;
          w_conflict_nxt = 1'b0;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase

    // Every state change starts both counters from zero.
    if (w_state_nxt != r_state) begin
      w_timer_nxt  = '0;
      w_settle_nxt = '0;
    end

    if (w_state_nxt == S_ERR && r_state != S_ERR && r_err_count != 8'hFF)
      w_err_nxt = r_err_count + 8'd1;
  end

  assign armed     = (r_state == S_WAIT_SPACER) || (r_state == S_WAIT_RAIL);
  assign out_valid = (r_state == S_HOLD);
  assign out_data  = r_data;
  assign timeout   = r_timeout;
  assign conflict  = r_conflict;
  assign err_count = r_err_count;

endmodule

// File: tb/tb_q_rail_receiver.sv
// Bench for q_rail_receiver: directed scenarios with literal expectations plus
// randomized traffic compared every cycle against a behavioural model.
module tb_q_rail_receiver;

  localparam int TIMEOUT = 8;
  localparam int SETTLE  = 2;

  localparam int P_IDLE   = 0;
  localparam int P_SPACER = 1;
  localparam int P_RAIL   = 2;
  localparam int P_HOLD   = 3;
  localparam int P_ERR    = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rh_l = 1'b1;
  logic       rl_l = 1'b1;
  logic       arm = 1'b0;
  logic       out_ready = 1'b0;
  logic       armed, out_valid, out_data, timeout, conflict;
  logic [7:0] err_count;

  int checks = 0;
  int failures = 0;

  q_rail_receiver #(
    .TIMEOUT(TIMEOUT),
    .SETTLE (SETTLE)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .rh_l     (rh_l),
    .rl_l     (rl_l),
    .arm      (arm),
    .armed    (armed),
    .out_valid(out_valid),
    .out_data (out_data),
    .out_ready(out_ready),
    .timeout  (timeout),
    .conflict (conflict),
    .err_count(err_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Behavioural model: phase plus run-length counters, synchroniser as a 2-deep history.
  int   ph = P_IDLE;
  int   run = 0;
  int   waited = 0;
  int   m_errs = 0;
  logic m_data = 1'b0;
  logic m_to = 1'b0;
  logic m_cf = 1'b0;
  logic m_s1h = 1'b1, m_s2h = 1'b1, m_s1l = 1'b1, m_s2l = 1'b1;

  always @(posedge clk) begin
    int  nph;
    bit  fh, fl;
    if (rst) begin
      ph = P_IDLE; run = 0; waited = 0; m_errs = 0;
      m_data = 1'b0; m_to = 1'b0; m_cf = 1'b0;
      m_s1h = 1'b1; m_s2h = 1'b1; m_s1l = 1'b1; m_s2l = 1'b1;
    end else begin
      fh  = !m_s2h;
      fl  = !m_s2l;
      nph = ph;
      case (ph)
        P_IDLE: if (arm) begin nph = P_SPACER; run = 0; end
        P_SPACER: begin
          run = (!fh && !fl) ? run + 1 : 0;
          if (run == SETTLE) begin nph = P_RAIL; waited = 0; end
        end
        P_RAIL: begin
          waited++;
          if (fh && fl) begin nph = P_ERR; m_cf = 1'b1; end
          else if (fh || fl) begin nph = P_HOLD; m_data = fh; end
          else if (waited == TIMEOUT) begin nph = P_ERR; m_to = 1'b1; end
        end
        P_HOLD: if (out_ready) begin nph = arm ? P_SPACER : P_IDLE; run = 0; end
        P_ERR: if (arm) begin nph = P_SPACER; run = 0; m_to = 1'b0; m_cf = 1'b0; end
        default: nph = P_IDLE;
      endcase
      if (nph == P_ERR && ph != P_ERR) m_errs = (m_errs >= 255) ? 255 : m_errs + 1;
      ph = nph;
      m_s2h = m_s1h; m_s1h = rh_l;
      m_s2l = m_s1l; m_s1l = rl_l;
    end
  end

  always @(posedge clk) begin
    #1;
    check("armed", armed, (ph == P_SPACER || ph == P_RAIL));
    check("out_valid", out_valid, (ph == P_HOLD));
    if (ph == P_HOLD) check("out_data", out_data, m_data);
    check("timeout", timeout, m_to);
    check("conflict", conflict, m_cf);
    check("err_count", err_count, m_errs);
  end

  int pcts[4] = '{0, 3, 10, 40};

  initial begin
    // Reset
    rst = 1'b1; tick(); tick(); rst = 1'b0;
    check("rst_armed", armed, 0);
    check("rst_valid", out_valid, 0);
    check("rst_data", out_data, 0);
    check("rst_timeout", timeout, 0);
    check("rst_conflict", conflict, 0);
    check("rst_errcnt", err_count, 0);

    // Normal resolve, high
    tick();
    arm = 1'b1; tick(); arm = 1'b0;
    check("arm_latency", armed, 1);
    tick(); tick();
    rh_l = 1'b0;
    tick(); check("hi_lat_e0", out_valid, 0);
    tick(); check("hi_lat_e1", out_valid, 0);
    tick(); check("hi_lat_e2", out_valid, 1);
    check("hi_data", out_data, 1);
    check("model_hi_valid", (ph == P_HOLD), 1);
    rh_l = 1'b1; out_ready = 1'b1;
    tick(); out_ready = 1'b0;
    check("hs_valid_drop", out_valid, 0);
    check("hs_idle_armed", armed, 0);

    // Normal resolve, low, then back-to-back arm
    tick(); tick();
    arm = 1'b1; tick(); arm = 1'b0;
    tick(); tick();
    rl_l = 1'b0;
    tick(); tick(); tick();
    check("lo_valid", out_valid, 1);
    check("lo_data", out_data, 0);
    rl_l = 1'b1;
    repeat (5) begin
      tick();
      check("stall_valid", out_valid, 1);
      check("stall_data", out_data, 0);
    end
    out_ready = 1'b1; arm = 1'b1;
    tick(); out_ready = 1'b0; arm = 1'b0;
    check("b2b_valid", out_valid, 0);
    check("b2b_armed", armed, 1);

    // Timeout: WAIT_RAIL entered after two more edges, then exactly TIMEOUT cycles
    tick(); tick();
    repeat (TIMEOUT - 1) tick();
    check("to_early", timeout, 0);
    check("to_early_armed", armed, 1);
    tick();
    check("to_flag", timeout, 1);
    check("to_armed", armed, 0);
    check("to_errcnt", err_count, 1);
    check("model_to_errs", m_errs, 1);

    // Rail seen on the final timer cycle wins over timeout
    arm = 1'b1; tick(); arm = 1'b0;
    check("to_clear", timeout, 0);
    tick(); tick();
    repeat (5) tick();
    rh_l = 1'b0;
    tick(); tick();
    check("last_pre_valid", out_valid, 0);
    tick();
    check("last_valid", out_valid, 1);
    check("last_no_to", timeout, 0);
    check("last_errcnt", err_count, 1);
    rh_l = 1'b1; out_ready = 1'b1; tick(); out_ready = 1'b0;

    // Conflict
    tick(); tick(); tick();
    arm = 1'b1; tick(); arm = 1'b0;
    tick(); tick();
    rh_l = 1'b0; rl_l = 1'b0;
    tick(); tick(); tick();
    check("cf_flag", conflict, 1);
    check("cf_valid", out_valid, 0);
    check("cf_no_to", timeout, 0);
    check("cf_errcnt", err_count, 2);
    rh_l = 1'b1; rl_l = 1'b1;
    tick();
    check("cf_sticky", conflict, 1);
    arm = 1'b1; tick(); arm = 1'b0;
    check("cf_clear", conflict, 0);
    check("cf_rearm", armed, 1);

    // Reset mid WAIT_RAIL
    tick(); tick(); tick();
    rst = 1'b1; tick(); rst = 1'b0;
    check("mid_rst_armed", armed, 0);
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_errcnt", err_count, 0);

    // Spacer gating: WAIT_RAIL only SETTLE cycles after s2 returns to spacer
    rh_l = 1'b0; tick(); tick(); tick();
    arm = 1'b1; tick(); arm = 1'b0;
    repeat (4) tick();
    check("gate_armed", armed, 1);
    check("gate_no_to", timeout, 0);
    rh_l = 1'b1;
    repeat (2 + SETTLE + TIMEOUT - 1) tick();
    check("gate_to_early", timeout, 0);
    tick();
    check("gate_to", timeout, 1);

    // Saturation: arm held, rails at spacer, ~300 timeouts
    arm = 1'b1;
    repeat (300 * (1 + SETTLE + TIMEOUT)) tick();
    arm = 1'b0;
    tick();
    check("sat_errcnt", err_count, 255);
    check("model_sat", m_errs, 255);

    // Randomized traffic, model compared every cycle
    for (int blk = 0; blk < 12; blk++) begin
      int pct;
      pct = pcts[blk % 4];
      repeat (250) begin
        rst       = ($urandom_range(0, 199) == 0);
        arm       = ($urandom_range(0, 3) == 0);
        out_ready = $urandom_range(0, 1) != 0;
        rh_l      = !($urandom_range(0, 99) < pct);
        rl_l      = !($urandom_range(0, 99) < pct);
        tick();
      end
    end
    rst = 1'b0; arm = 1'b0; out_ready = 1'b0; rh_l = 1'b1; rl_l = 1'b1;
    tick(); tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
